stf_detector: RTL and testbench



---
 rtl/stf_detector_if.sv | 22 ++
 rtl/stf_detector.sv | 209 ++++++++++++++++++++
 tb/tb_stf_detector.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/stf_detector_if.sv
// Baseband sample / detection bundle for the STF detector.
// The front end drives the master side; the detector is the slave.
interface stf_detector_if;
  logic        enable;
  logic [31:0] sample_in;
  logic        sample_in_strobe;
  logic [39:0] min_power;
  logic        short_preamble_detected;
  logic [39:0] corr_re_out;
  logic [39:0] corr_im_out;
  logic        busy;

  modport master (
    output enable, sample_in, sample_in_strobe, min_power,
    input  short_preamble_detected, corr_re_out, corr_im_out, busy
  );

  modport slave (
    input  enable, sample_in, sample_in_strobe, min_power,
    output short_preamble_detected, corr_re_out, corr_im_out, busy
  );
endinterface

// File: rtl/stf_detector.sv
// Short training field detector: delay-PERIOD autocorrelation over a WINDOW
// moving sum, normalised by windowed power, with hit run / holdoff FSM.
module stf_detector #(
  parameter int PERIOD     = 16,
  parameter int WINDOW     = 16,
  parameter int THRESH_NUM = 6,
  parameter int MIN_HITS   = 48,
  parameter int HOLDOFF    = 160
) (
  input  logic         clock,
  input  logic         reset,
  stf_detector_if.slave bus
);

  localparam int FILL_LEN = PERIOD + WINDOW - 1;
  localparam int FCW      = $clog2(FILL_LEN + 2);
  localparam int HCW      = $clog2(MIN_HITS + 2);
  localparam int HDW      = $clog2(HOLDOFF + 2);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  function automatic logic [43:0] mag44(input logic [39:0] x);
    logic [39:0] m;
    m = x[39] ? (~x + 40'd1) : x;
    return {4'd0, m};
  endfunction

  logic                stb_s;
  logic [31:0]         sdly_q [PERIOD];
  logic [FCW-1:0]      fill_cnt_q;
  logic signed [32:0]  s_i_s, s_q_s, d_i_s, d_q_s;
  logic signed [32:0]  p_re_s, p_im_s, p_pw_s;

  logic signed [32:0]  p_re_q, p_im_q;
  logic [32:0]         p_pw_q;
  logic                v1_q, mv1_q;

  logic signed [32:0]  pre_dly_q [WINDOW];
  logic signed [32:0]  pim_dly_q [WINDOW];
  logic [32:0]         ppw_dly_q [WINDOW];
  logic signed [39:0]  corr_re_q, corr_im_q;
  logic [39:0]         pow_q;
  logic                v2_q, mv2_q;

  logic [43:0]         lhs_s, rhs_s;
  logic                hit_s;
  logic [HCW-1:0]      new_cnt_s;

  logic [1:0]          state_q, state_d;
  logic [HCW-1:0]      hit_cnt_q, hit_cnt_d;
  logic [HDW-1:0]      hold_cnt_q, hold_cnt_d;
  logic                det_q, det_d;
  logic [39:0]         re_out_q, re_out_d;
  logic [39:0]         im_out_q, im_out_d;
  logic                busy_q, busy_d;

  assign stb_s = bus.sample_in_strobe & bus.enable;

  assign s_i_s = 33'($signed(bus.sample_in[31:16]));
  assign s_q_s = 33'($signed(bus.sample_in[15:0]));
  assign d_i_s = 33'($signed(sdly_q[PERIOD-1][31:16]));
  assign d_q_s = 33'($signed(sdly_q[PERIOD-1][15:0]));

  assign p_re_s = s_i_s * d_i_s + s_q_s * d_q_s;
  assign p_im_s = s_q_s * d_i_s - s_i_s * d_q_s;
  assign p_pw_s = s_i_s * s_i_s + s_q_s * s_q_s;

  // Sample delay line, fill counter and stage-1 products
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < PERIOD; k++) sdly_q[k] <= 32'd0;
      fill_cnt_q <= '0;
      p_re_q     <= 33'sd0;
      p_im_q     <= 33'sd0;
      p_pw_q     <= 33'd0;
      v1_q       <= 1'b0;
      mv1_q      <= 1'b0;
    end else begin
      v1_q <= stb_s;
      if (stb_s) begin
        for (int k = PERIOD - 1; k > 0; k--) sdly_q[k] <= sdly_q[k-1];
        sdly_q[0] <= bus.sample_in;
        if (fill_cnt_q != FCW'(FILL_LEN)) fill_cnt_q <= fill_cnt_q + FCW'(1);
        p_re_q <= p_re_s;
        p_im_q <= p_im_s;
        p_pw_q <= $unsigned(p_pw_s);
        mv1_q  <= (fill_cnt_q == FCW'(FILL_LEN));
      end
    end
  end

  // Product delay lines and moving sums over WINDOW valid products
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < WINDOW; k++) begin
        pre_dly_q[k] <= 33'sd0;
        pim_dly_q[k] <= 33'sd0;
        ppw_dly_q[k] <= 33'd0;
      end
      corr_re_q <= 40'sd0;
      corr_im_q <= 40'sd0;
      pow_q     <= 40'd0;
      v2_q      <= 1'b0;
      mv2_q     <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        for (int k = WINDOW - 1; k > 0; k--) begin
          pre_dly_q[k] <= pre_dly_q[k-1];
          pim_dly_q[k] <= pim_dly_q[k-1];
          ppw_dly_q[k] <= ppw_dly_q[k-1];
        end
        pre_dly_q[0] <= p_re_q;
        pim_dly_q[0] <= p_im_q;
        ppw_dly_q[0] <= p_pw_q;
        corr_re_q <= corr_re_q + 40'(p_re_q) - 40'(pre_dly_q[WINDOW-1]);
        corr_im_q <= corr_im_q + 40'(p_im_q) - 40'(pim_dly_q[WINDOW-1]);
        pow_q     <= pow_q + {7'd0, p_pw_q} - {7'd0, ppw_dly_q[WINDOW-1]};
        mv2_q     <= mv1_q;
      end
    end
  end

  assign lhs_s     = (mag44(corr_re_q) + mag44(corr_im_q)) * 44'd8;
  assign rhs_s     = {4'd0, pow_q} * 44'(THRESH_NUM);
  assign hit_s     = (lhs_s >= rhs_s) && (pow_q >= bus.min_power);
  assign new_cnt_s = (state_q == ST_COUNT) ? (hit_cnt_q + HCW'(1)) : HCW'(1);

  // Detection FSM, stepped once per stage-2 valid sample; the first valid
  // metric is evaluated in the same step that leaves FILL.
  always_comb begin
    state_d    = state_q;
    hit_cnt_d  = hit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    det_d      = 1'b0;
    re_out_d   = re_out_q;
    im_out_d   = im_out_q;
    if (v2_q) begin
      case (state_q)
        ST_FILL, ST_SEARCH, ST_COUNT: begin
          if (!mv2_q) begin
            state_d = ST_FILL;
          end else if (hit_s) begin
            if (new_cnt_s == HCW'(MIN_HITS)) begin
              det_d      = 1'b1;
              re_out_d   = corr_re_q;
              im_out_d   = corr_im_q;
              hit_cnt_d  = '0;
              hold_cnt_d = HDW'(HOLDOFF);
              state_d    = (HOLDOFF == 0) ? ST_SEARCH : ST_HOLD;
            end else begin
              hit_cnt_d = new_cnt_s;
              state_d   = ST_COUNT;
            end
          end else begin
            hit_cnt_d = '0;
            state_d   = ST_SEARCH;
          end
        end
        ST_HOLD: begin
          hold_cnt_d = hold_cnt_q - HDW'(1);
          if (hold_cnt_q == HDW'(1)) begin
            state_d = ST_SEARCH;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d    = ST_FILL;
          hit_cnt_d  = '0;
          hold_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d == ST_COUNT) || (state_d == ST_HOLD);
  end

  // FSM state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_FILL;
      hit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      det_q      <= 1'b0;
      re_out_q   <= 40'd0;
      im_out_q   <= 40'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      det_q      <= det_d;
      re_out_q   <= re_out_d;
      im_out_q   <= im_out_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.short_preamble_detected = det_q;
  assign bus.corr_re_out             = re_out_q;
  assign bus.corr_im_out             = im_out_q;
  assign bus.busy                    = busy_q;

endmodule

// File: tb/tb_stf_detector.sv
// Scoreboard bench for stf_detector: expected pulses are queued by the
// stimulus, and a negedge monitor pops and checks each detection pulse.
module tb_stf_detector;

  typedef struct {
    int     idx;
    longint re;
    longint im;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  stf_detector_if bus();

  stf_detector dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   sb[$];
  int     cur_idx  = 0;
  bit     hv [4];
  int     hi [4];
  bit     busy_watch = 1'b0;
  bit     busy_seen  = 1'b0;
  longint p_exp;

  // Periodic 16-sample pattern; sample 2 carries a large share of the energy
  int ti [16] = '{1000, -1300, 4000, 1400, 900, 1400, -100, -1300,
                  500, 0, -800, -100, 0, -100, -800, 0};
  int tq [16] = '{1000, 0, 0, -100, 0, -100, -800, 0,
                  500, -1300, -100, 1400, 900, 1400, -100, -1300};

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [31:0] mk(input int i, input int q);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'(i);
    b = 16'(q);
    return {a, b};
  endfunction

  // Monitor: tracks qualified strobes and checks each pulse against the queue
  always @(negedge clock) begin
    exp_t e;
    for (int k = 3; k > 0; k--) begin
      hv[k] = hv[k-1];
      hi[k] = hi[k-1];
    end
    hv[0] = bus.sample_in_strobe & bus.enable;
    hi[0] = cur_idx;
    if (busy_watch && bus.busy) busy_seen = 1'b1;
    if (bus.short_preamble_detected) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: pulse after sample %0d, none expected", hi[3]);
      end else begin
        e = sb.pop_front();
        chk("pulse_index", hv[3] ? hi[3] : -1, e.idx);
        chk("corr_re_out", $signed(bus.corr_re_out), e.re);
        chk("corr_im_out", $signed(bus.corr_im_out), e.im);
      end
    end
  end

  task automatic put(input logic [31:0] smp, input int idx, input int gap);
    @(posedge clock); #1;
    bus.sample_in        = smp;
    bus.sample_in_strobe = 1'b1;
    bus.enable           = 1'b1;
    cur_idx              = idx;
    for (int g = 0; g < gap; g++) begin
      @(posedge clock); #1;
      if (g == 0) begin
        bus.sample_in        = 32'hDEAD_BEEF;
        bus.sample_in_strobe = 1'b1;
        bus.enable           = 1'b0;
      end else begin
        bus.sample_in_strobe = 1'b0;
        bus.enable           = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      bus.sample_in_strobe = 1'b0;
      bus.enable           = 1'b1;
    end
  endtask

  task automatic stream(input int first, input int last, input int phase,
                        input int gap, input int bad, input bit zero);
    for (int k = first; k <= last; k++) begin
      int t;
      int i;
      int q;
      t = (k + phase) % 16;
      i = zero ? 0 : ti[t];
      q = zero ? 0 : tq[t];
      if (k == bad) i = -i;
      put(mk(i, q), k, gap);
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset                = 1'b1;
    bus.sample_in_strobe = 1'b0;
    bus.enable           = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset_pulse", bus.short_preamble_detected, 0);
    chk("reset_corr_re", bus.corr_re_out, 0);
    chk("reset_corr_im", bus.corr_im_out, 0);
    chk("reset_busy", bus.busy, 0);
  endtask

  task automatic expect_pulse(input int idx);
    exp_t e;
    e.idx = idx;
    e.re  = p_exp;
    e.im  = 0;
    sb.push_back(e);
  endtask

  initial begin
    bus.enable           = 1'b1;
    bus.sample_in        = 32'd0;
    bus.sample_in_strobe = 1'b0;
    bus.min_power        = 40'd1;
    p_exp = 0;
    for (int k = 0; k < 16; k++) p_exp += longint'(ti[k]) * ti[k] + longint'(tq[k]) * tq[k];

    // 1: back-to-back periodic stream, single pulse at 78, then holdoff
    do_reset();
    expect_pulse(78);
    stream(0, 159, 0, 0, -1, 1'b0);
    idle(8);
    @(negedge clock);
    chk("s1_busy_holdoff", bus.busy, 1);
    chk("s1_queue_empty", sb.size(), 0);

    // 2: strobe every third cycle, masked junk sample in each gap
    do_reset();
    expect_pulse(78);
    stream(0, 99, 0, 2, -1, 1'b0);
    idle(8);
    chk("s2_queue_empty", sb.size(), 0);

    // 3: all-zero input never hits
    do_reset();
    busy_watch = 1'b1;
    busy_seen  = 1'b0;
    stream(0, 499, 0, 0, -1, 1'b1);
    idle(8);
    busy_watch = 1'b0;
    chk("s3_busy_seen", busy_seen, 0);

    // 4: corrupted sample 50 breaks the run; misses 50..81, pulse at 82+47
    do_reset();
    expect_pulse(129);
    stream(0, 199, 0, 0, 50, 1'b0);
    idle(8);
    chk("s4_queue_empty", sb.size(), 0);

    // 5: long stream, pulses at 78 and 78+160+48
    do_reset();
    expect_pulse(78);
    expect_pulse(286);
    stream(0, 399, 0, 0, -1, 1'b0);
    idle(8);
    chk("s5_queue_empty", sb.size(), 0);

    // 6: reset mid-COUNT, stream resumes at pattern phase 60
    do_reset();
    stream(0, 59, 0, 0, -1, 1'b0);
    @(negedge clock);
    chk("s6_busy_count", bus.busy, 1);
    do_reset();
    expect_pulse(78);
    stream(0, 70, 60, 0, -1, 1'b0);
    @(negedge clock);
    chk("s6_corr_re_hold0", bus.corr_re_out, 0);
    chk("s6_corr_im_hold0", bus.corr_im_out, 0);
    stream(71, 120, 60, 0, -1, 1'b0);
    idle(8);
    chk("s6_queue_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
